// File: rtl/mux_16x1_structural_pkg.sv
// -----------------------------------------------------------------------------
// mux_16x1_structural_pkg
// Shared constants for the 16:1 structural multiplexer and its 2:1 tree.
//   N_IN   : number of data channels
//   SEL_W  : width of the channel select
//   L1_N.. : number of 2:1 cells in each tree level (8/4/2/1)
// -----------------------------------------------------------------------------
package mux_16x1_structural_pkg;

    localparam int N_IN  = 16;
    localparam int SEL_W = 4;

    // Each tree level halves the number of live candidates.
    localparam int L1_N  = N_IN / 2;
    localparam int L2_N  = L1_N / 2;
    localparam int L3_N  = L2_N / 2;

endpackage : mux_16x1_structural_pkg

// File: rtl/mux_16x1_structural_mux2x1.sv
// -----------------------------------------------------------------------------
// mux2x1
// W-bit 2:1 multiplexer cell used as the building block of the 16:1 tree.
//   a : input  [W-1:0]  selected when s = 0
//   b : input  [W-1:0]  selected when s = 1
//   s : input           select
//   y : output [W-1:0]  selected data
// An unknown select drives an unknown result instead of silently picking a
// leg; a plain ternary would hide an X select whenever a and b agree.
// -----------------------------------------------------------------------------
module mux2x1 #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = (s == 1'b1) ? b :
               ((s == 1'b0) ? a : {W{1'bx}});

endmodule : mux2x1

// File: rtl/mux_16x1_structural.sv
// -----------------------------------------------------------------------------
// mux_16x1_structural
// 16:1 multiplexer built as a four-level tree of mux2x1 cells, with a
// registered copy of the selected data and of the select.
//   clk   : input            rising-edge clock for the output register
//   rst_n : input            asynchronous active-low reset
//   in    : input  [16*W-1:0] channel k at bits [k*W+W-1 : k*W]
//   sel   : input  [3:0]     channel select 0..15
//   en    : input            capture enable for out_q / sel_q
//   out   : output [W-1:0]   combinational selected channel
//   out_q : output [W-1:0]   registered copy of out
//   sel_q : output [3:0]     registered copy of sel, captured with out_q
// -----------------------------------------------------------------------------
module mux_16x1_structural
    import mux_16x1_structural_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IN*W-1:0]   in,
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    output logic [W-1:0]        out,
    output logic [W-1:0]        out_q,
    output logic [SEL_W-1:0]    sel_q
);

    // Tree nodes: level n holds the survivors after select bit n-1.
    logic [W-1:0] w_l1_s [L1_N];
    logic [W-1:0] w_l2_s [L2_N];
    logic [W-1:0] w_l3_s [L3_N];
    logic [W-1:0] w_l4_s;

    logic [W-1:0]     r_out_q_r;
    logic [SEL_W-1:0] r_sel_q_r;

    // Level 1: pair adjacent channels on sel[0].
    for (genvar i = 0; i < L1_N; i++) begin : g_l1
        mux2x1 #(.W(W)) u_mux (
            .a (in[(2*i)*W   +: W]),
            .b (in[(2*i+1)*W +: W]),
            .s (sel[0]),
            .y (w_l1_s[i])
        );
    end

    // Level 2: pair level-1 results on sel[1].
    for (genvar i = 0; i < L2_N; i++) begin : g_l2
        mux2x1 #(.W(W)) u_mux (
            .a (w_l1_s[2*i]),
            .b (w_l1_s[2*i+1]),
            .s (sel[1]),
            .y (w_l2_s[i])
        );
    end

    // Level 3: pair level-2 results on sel[2].
    for (genvar i = 0; i < L3_N; i++) begin : g_l3
        mux2x1 #(.W(W)) u_mux (
            .a (w_l2_s[2*i]),
            .b (w_l2_s[2*i+1]),
            .s (sel[2]),
            .y (w_l3_s[i])
        );
    end

    // Level 4: final choice on the select MSB.
    mux2x1 #(.W(W)) u_mux_l4 (
        .a (w_l3_s[0]),
        .b (w_l3_s[1]),
        .s (sel[3]),
        .y (w_l4_s)
    );

    assign out = w_l4_s;

    // Output register: capture the tree result and its select when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q_r <= {W{1'b0}};
            r_sel_q_r <= {SEL_W{1'b0}};
        end else if (en) begin
            r_out_q_r <= w_l4_s;
            r_sel_q_r <= sel;
        end else begin
            r_out_q_r <= r_out_q_r;
            r_sel_q_r <= r_sel_q_r;
        end
    end

    assign out_q = r_out_q_r;
    assign sel_q = r_sel_q_r;

endmodule : mux_16x1_structural

// File: tb/tb_mux_16x1_structural.sv
// -----------------------------------------------------------------------------
// tb_mux_16x1_structural
// Self-checking bench for mux_16x1_structural at W=1 and W=8. Expected values
// are queued when stimulus is applied and compared when the output is sampled.
// -----------------------------------------------------------------------------
module tb_mux_16x1_structural;

    logic         clk;
    logic         rst_n;

    // W=1 instance
    logic [15:0]  in1;
    logic [3:0]   sel1;
    logic         en1;
    logic         out1;
    logic         out_q1;
    logic [3:0]   sel_q1;

    // W=8 instance
    logic [127:0] in8;
    logic [3:0]   sel8;
    logic         en8;
    logic [7:0]   out8;
    logic [7:0]   out_q8;
    logic [3:0]   sel_q8;

    int n_checks;
    int n_fail;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] chan[16];

    mux_16x1_structural #(.W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in1),
        .sel   (sel1),
        .en    (en1),
        .out   (out1),
        .out_q (out_q1),
        .sel_q (sel_q1)
    );

    mux_16x1_structural #(.W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in8),
        .sel   (sel8),
        .en    (en8),
        .out   (out8),
        .out_q (out_q8),
        .sel_q (sel_q8)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void sb_push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endfunction

    task automatic sb_pop_check(input logic [7:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 8'(sb_q.size()), 8'd1);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        in1 = 16'h0000; sel1 = 4'h0; en1 = 1'b0;
        in8 = 128'h0;   sel8 = 4'h0; en8 = 1'b0;

        // Reset state, no clock edge yet.
        #2;
        check_val("rst_out_q1", {7'b0, out_q1}, 8'h00);
        check_val("rst_sel_q1", {4'b0, sel_q1}, 8'h00);
        check_val("rst_out_q8", out_q8, 8'h00);
        check_val("rst_sel_q8", {4'b0, sel_q8}, 8'h00);

        // Fixed pattern, combinational path works while in reset.
        in1 = 16'h3F0A;
        sel1 = 4'h0; sb_push("pat_sel0", 8'h00); #5; sb_pop_check({7'b0, out1});
        sel1 = 4'h1; sb_push("pat_sel1", 8'h01); #5; sb_pop_check({7'b0, out1});
        sel1 = 4'h6; sb_push("pat_sel6", 8'h00); #5; sb_pop_check({7'b0, out1});
        sel1 = 4'hA; sb_push("pat_selA", 8'h01); #5; sb_pop_check({7'b0, out1});
        sel1 = 4'hF; sb_push("pat_selF", 8'h00); #5; sb_pop_check({7'b0, out1});

        // Walking one across every channel and every select value.
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 16; s++) begin
                in1  = 16'h0001 << k;
                sel1 = 4'(s);
                sb_push("walk", {7'b0, (k == s)});
                #1;
                sb_pop_check({7'b0, out1});
            end
        end

        // Reset holds registers even with en=1; out still follows.
        in1 = 16'hFFFF; sel1 = 4'h3; en1 = 1'b1;
        #1;
        check_val("rst_out_live", {7'b0, out1}, 8'h01);
        check_val("rst_out_q_hold", {7'b0, out_q1}, 8'h00);
        check_val("rst_sel_q_hold", {4'b0, sel_q1}, 8'h00);

        // Release and capture on the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        sb_push("rel_out_q", 8'h01);
        sb_push("rel_sel_q", 8'h03);
        @(posedge clk); #1;
        sb_pop_check({7'b0, out_q1});
        sb_pop_check({4'b0, sel_q1});

        // en=0 holds across three edges while out moves.
        @(negedge clk);
        en1 = 1'b0; sel1 = 4'h4; in1 = 16'h0008;
        sb_push("hold_out", 8'h00);
        #1;
        sb_pop_check({7'b0, out1});
        for (int c = 0; c < 3; c++) begin
            sb_push("hold_out_q", 8'h01);
            sb_push("hold_sel_q", 8'h03);
            @(posedge clk); #1;
            sb_pop_check({7'b0, out_q1});
            sb_pop_check({4'b0, sel_q1});
        end
        @(negedge clk);
        en1 = 1'b1;
        sb_push("en_out_q", 8'h00);
        sb_push("en_sel_q", 8'h04);
        @(posedge clk); #1;
        sb_pop_check({7'b0, out_q1});
        sb_pop_check({4'b0, sel_q1});

        // Mid-cycle reset clears the register before the next edge.
        @(negedge clk);
        sel1 = 4'h3;
        sb_push("pre_rst_out_q", 8'h01);
        @(posedge clk); #1;
        sb_pop_check({7'b0, out_q1});
        @(negedge clk); #2;
        rst_n = 1'b0;
        sb_push("async_out_q", 8'h00);
        sb_push("async_sel_q", 8'h00);
        sb_push("async_out", 8'h01);
        #1;
        sb_pop_check({7'b0, out_q1});
        sb_pop_check({4'b0, sel_q1});
        sb_pop_check({7'b0, out1});
        @(negedge clk);
        rst_n = 1'b1;

        // W=8: channel k holds 8'h10+k, select 9.
        for (int k = 0; k < 16; k++) begin
            in8[k*8 +: 8] = 8'h10 + 8'(k);
        end
        sel8 = 4'h9; en8 = 1'b0;
        sb_push("w8_out", 8'h19);
        sb_push("w8_q_no_clk", 8'h00);
        #1;
        sb_pop_check(out8);
        sb_pop_check(out_q8);
        @(negedge clk);
        en8 = 1'b1;
        sb_push("w8_out_q", 8'h19);
        sb_push("w8_sel_q", 8'h09);
        @(posedge clk); #1;
        sb_pop_check(out_q8);
        sb_pop_check({4'b0, sel_q8});

        // W=8 random data and selects against a channel-array model.
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            for (int k = 0; k < 16; k++) begin
                chan[k] = 8'($urandom_range(255, 0));
                in8[k*8 +: 8] = chan[k];
            end
            sel8 = 4'($urandom_range(15, 0));
            sb_push("rnd_out", chan[sel8]);
            sb_push("rnd_out_q", chan[sel8]);
            sb_push("rnd_sel_q", {4'b0, sel8});
            #1;
            sb_pop_check(out8);
            @(posedge clk); #1;
            sb_pop_check(out_q8);
            sb_pop_check({4'b0, sel_q8});
        end

        check_val("sb_drain", 8'(sb_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_16x1_structural
